// File: rtl/hft_core_sequencer_if.sv
// hft_core_sequencer_if
// Bundles every non-clock signal of the sequencer into one interface.
//   master : sequencer view. Drives md_ready, the core_* operands, core_start,
//            the ord_* request, busy and the statistics counters.
//   slave  : environment view. This covers the feed handler, the decision core
//            and the order gateway.
// Signal groups:
//   md_*    market snapshot intake (valid strobe, md_ready is always 1)
//   fill_*  fill report intake
//   core_*  ap_ctrl_hs handshake, registered core operands and core decision
//   ord_*   valid/ready order request toward the gateway
//   stat_*  saturating or wrapping event counters
interface hft_core_sequencer_if;
    logic        md_valid;
    logic        md_ready;
    logic [31:0] md_bid_price;
    logic [31:0] md_ask_price;
    logic [31:0] md_bid_qty;
    logic [31:0] md_ask_qty;
    logic        md_bid_strong;
    logic        md_ask_strong;

    logic        fill_valid;
    logic        fill_side;
    logic [31:0] fill_price;
    logic [31:0] fill_qty;

    logic        core_start;
    logic        core_ready;
    logic        core_done;
    logic        core_idle;
    logic [31:0] core_bid_price;
    logic [31:0] core_ask_price;
    logic [31:0] core_bid_qty;
    logic [31:0] core_ask_qty;
    logic        core_bid_strong;
    logic        core_ask_strong;
    logic [31:0] core_position;
    logic [31:0] core_last_fill_price;
    logic        core_last_fill_side;
    logic [1:0]  core_action;
    logic [31:0] core_price;
    logic [31:0] core_quantity;

    logic        ord_valid;
    logic        ord_ready;
    logic        ord_side;
    logic [31:0] ord_price;
    logic [31:0] ord_qty;

    logic        busy;
    logic [15:0] stat_coalesced;
    logic [15:0] stat_timeouts;
    logic [15:0] stat_orders;

    modport master (
        input  md_valid, md_bid_price, md_ask_price, md_bid_qty, md_ask_qty,
               md_bid_strong, md_ask_strong,
               fill_valid, fill_side, fill_price, fill_qty,
               core_ready, core_done, core_idle, core_action, core_price, core_quantity,
               ord_ready,
        output md_ready, core_start,
               core_bid_price, core_ask_price, core_bid_qty, core_ask_qty,
               core_bid_strong, core_ask_strong,
               core_position, core_last_fill_price, core_last_fill_side,
               ord_valid, ord_side, ord_price, ord_qty,
               busy, stat_coalesced, stat_timeouts, stat_orders
    );

    modport slave (
        output md_valid, md_bid_price, md_ask_price, md_bid_qty, md_ask_qty,
               md_bid_strong, md_ask_strong,
               fill_valid, fill_side, fill_price, fill_qty,
               core_ready, core_done, core_idle, core_action, core_price, core_quantity,
               ord_ready,
        input  md_ready, core_start,
               core_bid_price, core_ask_price, core_bid_qty, core_ask_qty,
               core_bid_strong, core_ask_strong,
               core_position, core_last_fill_price, core_last_fill_side,
               ord_valid, ord_side, ord_price, ord_qty,
               busy, stat_coalesced, stat_timeouts, stat_orders
    );
endinterface

// File: rtl/hft_core_sequencer.sv
// hft_core_sequencer
// Sequences the hft_zero_plus decision core. Snapshots are buffered and
// coalesced to the newest one while the core is busy. The position and
// last-fill registers are maintained from fill reports. Each run goes through
// the ap_ctrl_hs handshake under a watchdog. BUY/SELL decisions are turned into
// a valid/ready order request.
// Ports:
//   ap_clk    clock
//   ap_rst_n  asynchronous active-low reset
//   bus       hft_core_sequencer_if.master (feed, fills, core, order, stats)
module hft_core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MIN_GAP        = 4
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    hft_core_sequencer_if.master   bus
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_EMIT, S_GAP} state_t;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] pend_bid_price_q, pend_bid_price_d;
    logic [31:0] pend_ask_price_q, pend_ask_price_d;
    logic [31:0] pend_bid_qty_q, pend_bid_qty_d;
    logic [31:0] pend_ask_qty_q, pend_ask_qty_d;
    logic        pend_bid_strong_q, pend_bid_strong_d;
    logic        pend_ask_strong_q, pend_ask_strong_d;
    logic [31:0] position_q, position_d;
    logic [31:0] last_fill_price_q, last_fill_price_d;
    logic        last_fill_side_q, last_fill_side_d;
    logic        core_start_q, core_start_d;
    logic [31:0] core_bid_price_q, core_bid_price_d;
    logic [31:0] core_ask_price_q, core_ask_price_d;
    logic [31:0] core_bid_qty_q, core_bid_qty_d;
    logic [31:0] core_ask_qty_q, core_ask_qty_d;
    logic        core_bid_strong_q, core_bid_strong_d;
    logic        core_ask_strong_q, core_ask_strong_d;
    logic [31:0] core_position_q, core_position_d;
    logic [31:0] core_lf_price_q, core_lf_price_d;
    logic        core_lf_side_q, core_lf_side_d;
    logic        ord_valid_q, ord_valid_d;
    logic        ord_side_q, ord_side_d;
    logic [31:0] ord_price_q, ord_price_d;
    logic [31:0] ord_qty_q, ord_qty_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] stat_coalesced_q, stat_coalesced_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;
    logic [15:0] stat_orders_q, stat_orders_d;

    logic launch;
    logic wd_expire;
    logic done_now;

    assign launch    = (state_q == S_IDLE) && pending_q && bus.core_idle;
    // The cycle being closed would be the TIMEOUT_CYCLES-th spent in START/WAIT.
    assign wd_expire = (wd_cnt_q + 32'd1) >= 32'(TIMEOUT_CYCLES);
    // A completion arriving on the expiry cycle takes priority over the abort.
    assign done_now  = ((state_q == S_START) && bus.core_ready && bus.core_done) ||
                       ((state_q == S_WAIT) && bus.core_done);

    // Next-state logic for intake buffers, position tracking and the run FSM.
    always_comb begin
        state_d           = state_q;
        pending_d         = pending_q;
        pend_bid_price_d  = pend_bid_price_q;
        pend_ask_price_d  = pend_ask_price_q;
        pend_bid_qty_d    = pend_bid_qty_q;
        pend_ask_qty_d    = pend_ask_qty_q;
        pend_bid_strong_d = pend_bid_strong_q;
        pend_ask_strong_d = pend_ask_strong_q;
        position_d        = position_q;
        last_fill_price_d = last_fill_price_q;
        last_fill_side_d  = last_fill_side_q;
        core_start_d      = core_start_q;
        core_bid_price_d  = core_bid_price_q;
        core_ask_price_d  = core_ask_price_q;
        core_bid_qty_d    = core_bid_qty_q;
        core_ask_qty_d    = core_ask_qty_q;
        core_bid_strong_d = core_bid_strong_q;
        core_ask_strong_d = core_ask_strong_q;
        core_position_d   = core_position_q;
        core_lf_price_d   = core_lf_price_q;
        core_lf_side_d    = core_lf_side_q;
        ord_valid_d       = ord_valid_q;
        ord_side_d        = ord_side_q;
        ord_price_d       = ord_price_q;
        ord_qty_d         = ord_qty_q;
        wd_cnt_d          = wd_cnt_q;
        gap_cnt_d         = gap_cnt_q;
        stat_coalesced_d  = stat_coalesced_q;
        stat_timeouts_d   = stat_timeouts_q;
        stat_orders_d     = stat_orders_q;

        // The launch consumes the buffer. A snapshot on the same edge refills it
        // and does not count as a coalesce.
        if (launch) begin
            pending_d = 1'b0;
        end
        if (bus.md_valid) begin
            pending_d         = 1'b1;
            pend_bid_price_d  = bus.md_bid_price;
            pend_ask_price_d  = bus.md_ask_price;
            pend_bid_qty_d    = bus.md_bid_qty;
            pend_ask_qty_d    = bus.md_ask_qty;
            pend_bid_strong_d = bus.md_bid_strong;
            pend_ask_strong_d = bus.md_ask_strong;
            if (pending_q && !launch && (stat_coalesced_q != 16'hFFFF)) begin
                stat_coalesced_d = stat_coalesced_q + 16'd1;
            end
        end

        if (bus.fill_valid) begin
            position_d        = bus.fill_side ? (position_q - bus.fill_qty)
                                              : (position_q + bus.fill_qty);
            last_fill_price_d = bus.fill_price;
            last_fill_side_d  = bus.fill_side;
        end

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    core_bid_price_d  = pend_bid_price_q;
                    core_ask_price_d  = pend_ask_price_q;
                    core_bid_qty_d    = pend_bid_qty_q;
                    core_ask_qty_d    = pend_ask_qty_q;
                    core_bid_strong_d = pend_bid_strong_q;
                    core_ask_strong_d = pend_ask_strong_q;
                    core_position_d   = position_q;
                    core_lf_price_d   = last_fill_price_q;
                    core_lf_side_d    = last_fill_side_q;
                    core_start_d      = 1'b1;
                    wd_cnt_d          = 32'd0;
                    state_d           = S_START;
                end
            end
            S_START, S_WAIT: begin
                wd_cnt_d = wd_cnt_q + 32'd1;
                if (done_now) begin
                    core_start_d = 1'b0;
                    gap_cnt_d    = 32'd0;
                    // Only 01 (buy) and 10 (sell) produce an order. Bit 1 selects the side.
                    if (bus.core_action == 2'b01 || bus.core_action == 2'b10) begin
                        ord_valid_d = 1'b1;
                        ord_side_d  = bus.core_action[1];
                        ord_price_d = bus.core_price;
                        ord_qty_d   = bus.core_quantity;
                        state_d     = S_EMIT;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (wd_expire) begin
                    core_start_d = 1'b0;
                    gap_cnt_d    = 32'd0;
                    state_d      = S_GAP;
                    if (stat_timeouts_q != 16'hFFFF) begin
                        stat_timeouts_d = stat_timeouts_q + 16'd1;
                    end
                end else if (state_q == S_START && bus.core_ready) begin
                    core_start_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_EMIT: begin
                if (bus.ord_ready) begin
                    ord_valid_d   = 1'b0;
                    stat_orders_d = stat_orders_q + 16'd1;
                    gap_cnt_d     = 32'd0;
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 32'(MIN_GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q           <= S_IDLE;
            pending_q         <= 1'b0;
            pend_bid_price_q  <= '0;
            pend_ask_price_q  <= '0;
            pend_bid_qty_q    <= '0;
            pend_ask_qty_q    <= '0;
            pend_bid_strong_q <= 1'b0;
            pend_ask_strong_q <= 1'b0;
            position_q        <= '0;
            last_fill_price_q <= '0;
            last_fill_side_q  <= 1'b0;
            core_start_q      <= 1'b0;
            core_bid_price_q  <= '0;
            core_ask_price_q  <= '0;
            core_bid_qty_q    <= '0;
            core_ask_qty_q    <= '0;
            core_bid_strong_q <= 1'b0;
            core_ask_strong_q <= 1'b0;
            core_position_q   <= '0;
            core_lf_price_q   <= '0;
            core_lf_side_q    <= 1'b0;
            ord_valid_q       <= 1'b0;
            ord_side_q        <= 1'b0;
            ord_price_q       <= '0;
            ord_qty_q         <= '0;
            wd_cnt_q          <= '0;
            gap_cnt_q         <= '0;
            stat_coalesced_q  <= '0;
            stat_timeouts_q   <= '0;
            stat_orders_q     <= '0;
        end else begin
            state_q           <= state_d;
            pending_q         <= pending_d;
            pend_bid_price_q  <= pend_bid_price_d;
            pend_ask_price_q  <= pend_ask_price_d;
            pend_bid_qty_q    <= pend_bid_qty_d;
            pend_ask_qty_q    <= pend_ask_qty_d;
            pend_bid_strong_q <= pend_bid_strong_d;
            pend_ask_strong_q <= pend_ask_strong_d;
            position_q        <= position_d;
            last_fill_price_q <= last_fill_price_d;
            last_fill_side_q  <= last_fill_side_d;
            core_start_q      <= core_start_d;
            core_bid_price_q  <= core_bid_price_d;
            core_ask_price_q  <= core_ask_price_d;
            core_bid_qty_q    <= core_bid_qty_d;
            core_ask_qty_q    <= core_ask_qty_d;
            core_bid_strong_q <= core_bid_strong_d;
            core_ask_strong_q <= core_ask_strong_d;
            core_position_q   <= core_position_d;
            core_lf_price_q   <= core_lf_price_d;
            core_lf_side_q    <= core_lf_side_d;
            ord_valid_q       <= ord_valid_d;
            ord_side_q        <= ord_side_d;
            ord_price_q       <= ord_price_d;
            ord_qty_q         <= ord_qty_d;
            wd_cnt_q          <= wd_cnt_d;
            gap_cnt_q         <= gap_cnt_d;
            stat_coalesced_q  <= stat_coalesced_d;
            stat_timeouts_q   <= stat_timeouts_d;
            stat_orders_q     <= stat_orders_d;
        end
    end

    assign bus.md_ready             = 1'b1;
    assign bus.core_start           = core_start_q;
    assign bus.core_bid_price       = core_bid_price_q;
    assign bus.core_ask_price       = core_ask_price_q;
    assign bus.core_bid_qty         = core_bid_qty_q;
    assign bus.core_ask_qty         = core_ask_qty_q;
    assign bus.core_bid_strong      = core_bid_strong_q;
    assign bus.core_ask_strong      = core_ask_strong_q;
    assign bus.core_position        = core_position_q;
    assign bus.core_last_fill_price = core_lf_price_q;
    assign bus.core_last_fill_side  = core_lf_side_q;
    assign bus.ord_valid            = ord_valid_q;
    assign bus.ord_side             = ord_side_q;
    assign bus.ord_price            = ord_price_q;
    assign bus.ord_qty              = ord_qty_q;
    assign bus.busy                 = (state_q != S_IDLE);
    assign bus.stat_coalesced       = stat_coalesced_q;
    assign bus.stat_timeouts        = stat_timeouts_q;
    assign bus.stat_orders          = stat_orders_q;

endmodule

// File: tb/tb_hft_core_sequencer.sv
// tb_hft_core_sequencer
// Directed bench for hft_core_sequencer. Inputs are driven right after each
// falling edge. Outputs are sampled on falling edges, away from the active
// rising edge. Expected values are hand-computed constants.
module tb_hft_core_sequencer;

    localparam int TIMEOUT = 64;
    localparam int GAP     = 4;

    logic clk;
    logic rst_n;
    int   vectorCount;
    int   missCount;
    int   n;
    logic stable;

    hft_core_sequencer_if seq_if();

    hft_core_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .MIN_GAP(GAP)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (seq_if)
    );

    // Free-running clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so a broken design can never hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle market snapshot strobe.
    task automatic applyStimulus(input logic [31:0] bid, input logic [31:0] ask,
                                 input logic [31:0] bq, input logic [31:0] aq,
                                 input logic bs, input logic as_);
        seq_if.md_valid      = 1'b1;
        seq_if.md_bid_price  = bid;
        seq_if.md_ask_price  = ask;
        seq_if.md_bid_qty    = bq;
        seq_if.md_ask_qty    = aq;
        seq_if.md_bid_strong = bs;
        seq_if.md_ask_strong = as_;
        tick();
        seq_if.md_valid      = 1'b0;
    endtask

    task automatic applyFill(input logic side, input logic [31:0] qty, input logic [31:0] price);
        seq_if.fill_valid = 1'b1;
        seq_if.fill_side  = side;
        seq_if.fill_qty   = qty;
        seq_if.fill_price = price;
        tick();
        seq_if.fill_valid = 1'b0;
    endtask

    // Called at the falling edge right after the launch edge. core_ready and
    // core_done are sampled readyAt and doneAt rising edges later.
    task automatic doCoreRun(input int readyAt, input int doneAt, input logic [1:0] act,
                             input logic [31:0] pr, input logic [31:0] qty);
        int last;
        last = (readyAt > doneAt) ? readyAt : doneAt;
        for (int c = 1; c <= last; c++) begin
            seq_if.core_ready    = (c == readyAt);
            seq_if.core_done     = (c == doneAt);
            seq_if.core_action   = act;
            seq_if.core_price    = pr;
            seq_if.core_quantity = qty;
            tick();
        end
        seq_if.core_ready  = 1'b0;
        seq_if.core_done   = 1'b0;
        seq_if.core_action = 2'b00;
    endtask

    task automatic waitStart(output int cycles);
        cycles = 0;
        while (seq_if.core_start !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
        checkOutput("start_seen", seq_if.core_start, 32'd1);
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (seq_if.busy !== 1'b0 && cycles < 60) begin
            tick();
            cycles++;
        end
        checkOutput("idle_seen", seq_if.busy, 32'd0);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        rst_n                = 1'b0;
        seq_if.md_valid      = 1'b0;
        seq_if.md_bid_price  = '0;
        seq_if.md_ask_price  = '0;
        seq_if.md_bid_qty    = '0;
        seq_if.md_ask_qty    = '0;
        seq_if.md_bid_strong = 1'b0;
        seq_if.md_ask_strong = 1'b0;
        seq_if.fill_valid    = 1'b0;
        seq_if.fill_side     = 1'b0;
        seq_if.fill_price    = '0;
        seq_if.fill_qty      = '0;
        seq_if.core_ready    = 1'b0;
        seq_if.core_done     = 1'b0;
        seq_if.core_idle     = 1'b1;
        seq_if.core_action   = 2'b00;
        seq_if.core_price    = '0;
        seq_if.core_quantity = '0;
        seq_if.ord_ready     = 1'b0;

        // Reset state
        tick();
        checkOutput("rst_md_ready", seq_if.md_ready, 32'd1);
        checkOutput("rst_core_start", seq_if.core_start, 32'd0);
        checkOutput("rst_busy", seq_if.busy, 32'd0);
        checkOutput("rst_ord_valid", seq_if.ord_valid, 32'd0);
        checkOutput("rst_stats", {seq_if.stat_coalesced, seq_if.stat_orders}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic buy run
        $display("[TB] basic run");
        applyStimulus(32'd80300, 32'd80301, 32'd10, 32'd20, 1'b1, 1'b0);
        checkOutput("t1_no_start_yet", seq_if.core_start, 32'd0);
        tick();
        checkOutput("t1_start", seq_if.core_start, 32'd1);
        checkOutput("t1_bid", seq_if.core_bid_price, 32'd80300);
        checkOutput("t1_ask", seq_if.core_ask_price, 32'd80301);
        checkOutput("t1_qtys", seq_if.core_bid_qty + seq_if.core_ask_qty, 32'd30);
        checkOutput("t1_strong", {seq_if.core_bid_strong, seq_if.core_ask_strong}, 32'd2);
        doCoreRun(1, 3, 2'b01, 32'd80300, 32'd100);
        checkOutput("t1_ord_valid", seq_if.ord_valid, 32'd1);
        checkOutput("t1_ord_side", seq_if.ord_side, 32'd0);
        checkOutput("t1_ord_price", seq_if.ord_price, 32'd80300);
        checkOutput("t1_ord_qty", seq_if.ord_qty, 32'd100);
        seq_if.ord_ready = 1'b1;
        tick();
        seq_if.ord_ready = 1'b0;
        checkOutput("t1_ord_dropped", seq_if.ord_valid, 32'd0);
        checkOutput("t1_orders", seq_if.stat_orders, 32'd1);
        waitIdle(n);
        checkOutput("t1_gap_len", n, GAP);

        // Fills and position, no-op action 00
        $display("[TB] fills and position");
        applyFill(1'b0, 32'd200, 32'd5000);
        applyFill(1'b1, 32'd50, 32'd5001);
        applyStimulus(32'd1000, 32'd1001, 32'd1, 32'd1, 1'b0, 1'b0);
        tick();
        checkOutput("t3_start", seq_if.core_start, 32'd1);
        checkOutput("t3_position", seq_if.core_position, 32'd150);
        checkOutput("t3_lf_price", seq_if.core_last_fill_price, 32'd5001);
        checkOutput("t3_lf_side", seq_if.core_last_fill_side, 32'd1);
        doCoreRun(1, 2, 2'b00, 32'd1, 32'd1);
        checkOutput("t3_noop_no_order", seq_if.ord_valid, 32'd0);
        waitIdle(n);
        checkOutput("t3_gap_len", n, GAP);
        checkOutput("t3_orders", seq_if.stat_orders, 32'd1);
        applyFill(1'b1, 32'd300, 32'd5002);
        applyStimulus(32'd1002, 32'd1003, 32'd1, 32'd1, 1'b0, 1'b0);
        applyFill(1'b0, 32'd1000, 32'd5003);
        checkOutput("t3_launch_start", seq_if.core_start, 32'd1);
        checkOutput("t3_neg_position", seq_if.core_position, 32'hFFFFFF6A);
        checkOutput("t3_launch_lf_price", seq_if.core_last_fill_price, 32'd5002);

        // Watchdog: this run never completes
        $display("[TB] watchdog");
        applyStimulus(32'd2000, 32'd2001, 32'd5, 32'd5, 1'b0, 1'b1);
        for (int i = 0; i < TIMEOUT - 2; i++) tick();
        checkOutput("t4_start_held", seq_if.core_start, 32'd1);
        tick();
        checkOutput("t4_start_dropped", seq_if.core_start, 32'd0);
        checkOutput("t4_timeouts", seq_if.stat_timeouts, 32'd1);
        checkOutput("t4_no_order", seq_if.ord_valid, 32'd0);
        checkOutput("t4_busy_gap", seq_if.busy, 32'd1);
        waitStart(n);
        checkOutput("t4_relaunch_delay", n, GAP + 1);
        checkOutput("t4_position", seq_if.core_position, 32'd850);
        checkOutput("t4_lf", {seq_if.core_last_fill_price[30:0], seq_if.core_last_fill_side},
                    {31'd5003, 1'b0});
        checkOutput("t4_bid", seq_if.core_bid_price, 32'd2000);
        checkOutput("t4_coalesced", seq_if.stat_coalesced, 32'd0);

        // Single-cycle sell run, then backpressure
        $display("[TB] backpressure");
        doCoreRun(2, 2, 2'b10, 32'd80310, 32'd7);
        checkOutput("t5_ord_valid", seq_if.ord_valid, 32'd1);
        checkOutput("t5_ord_side", seq_if.ord_side, 32'd1);
        applyStimulus(32'd3000, 32'd3001, 32'd2, 32'd2, 1'b0, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            stable = stable && (seq_if.ord_valid === 1'b1) && (seq_if.ord_side === 1'b1) &&
                     (seq_if.ord_price === 32'd80310) && (seq_if.ord_qty === 32'd7) &&
                     (seq_if.core_start === 1'b0);
            tick();
        end
        checkOutput("t5_stable", stable, 32'd1);
        checkOutput("t5_coalesced", seq_if.stat_coalesced, 32'd0);
        seq_if.ord_ready = 1'b1;
        tick();
        seq_if.ord_ready = 1'b0;
        checkOutput("t5_orders", seq_if.stat_orders, 32'd2);
        checkOutput("t5_ord_dropped", seq_if.ord_valid, 32'd0);
        waitStart(n);
        checkOutput("t5_relaunch_delay", n, GAP + 1);
        checkOutput("t5_bid", seq_if.core_bid_price, 32'd3000);

        // Coalescing during a busy run, then invalid action 11
        $display("[TB] coalescing");
        applyStimulus(32'd80300, 32'd80400, 32'd1, 32'd1, 1'b0, 1'b0);
        applyStimulus(32'd80301, 32'd80401, 32'd1, 32'd1, 1'b0, 1'b0);
        applyStimulus(32'd80302, 32'd80402, 32'd1, 32'd1, 1'b0, 1'b0);
        checkOutput("t2_coalesced", seq_if.stat_coalesced, 32'd2);
        doCoreRun(1, 1, 2'b11, 32'd9, 32'd9);
        checkOutput("t2_invalid_no_order", seq_if.ord_valid, 32'd0);
        waitStart(n);
        checkOutput("t2_relaunch_delay", n, GAP + 1);
        checkOutput("t2_bid", seq_if.core_bid_price, 32'd80302);
        checkOutput("t2_ask", seq_if.core_ask_price, 32'd80402);
        checkOutput("t2_orders", seq_if.stat_orders, 32'd2);

        // Reset while waiting with a snapshot pending
        $display("[TB] reset mid-run");
        seq_if.core_ready = 1'b1;
        tick();
        seq_if.core_ready = 1'b0;
        checkOutput("t6_wait_start_low", seq_if.core_start, 32'd0);
        applyStimulus(32'd4000, 32'd4001, 32'd1, 32'd1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_busy", seq_if.busy, 32'd0);
        checkOutput("t6_md_ready", seq_if.md_ready, 32'd1);
        checkOutput("t6_core_regs", seq_if.core_bid_price | seq_if.core_position, 32'd0);
        checkOutput("t6_stats", {seq_if.stat_coalesced, seq_if.stat_orders}, 32'd0);
        checkOutput("t6_timeouts", seq_if.stat_timeouts, 32'd0);
        tick();
        rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            stable = stable && (seq_if.core_start === 1'b0);
        end
        checkOutput("t6_no_start_after_reset", stable, 32'd1);

        // A busy core holds off the launch
        seq_if.core_idle = 1'b0;
        applyStimulus(32'd5000, 32'd5001, 32'd1, 32'd1, 1'b0, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            stable = stable && (seq_if.core_start === 1'b0);
        end
        checkOutput("t6_core_busy_hold", stable, 32'd1);
        seq_if.core_idle = 1'b1;
        tick();
        checkOutput("t6_launch", seq_if.core_start, 32'd1);
        checkOutput("t6_bid", seq_if.core_bid_price, 32'd5000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
